// File: rtl/motor_plant_pkg.sv
// Shared types and constants for the motor/rotor plant model.
package motor_plant_pkg;
  typedef enum logic {INTEG = 1'b0, LAG = 1'b1} plant_mode_t;

  localparam int RPM_MAX_DEF = 'h157C;

  localparam int MOT_L  = 0;
  localparam int MOT_RT = 1;
  localparam int MOT_F  = 2;
  localparam int MOT_RV = 3;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
endpackage

// File: rtl/motor_plant_ch.sv
// One plant channel: input register, integrator/lag accumulator, clamp,
// saturation counter and sticky over-limit fault.
module motor_plant_ch
  import motor_plant_pkg::*;
#(
  parameter int W          = 16,
  parameter int GAIN_SHIFT = 3,
  parameter int RPM_MAX    = RPM_MAX_DEF,
  parameter int SAT_LIMIT  = 64,
  parameter int CW         = $clog2(SAT_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_tick,
  input  plant_mode_t         i_mode,
  input  logic                i_fault_clr,
  input  logic signed [W-1:0] i_set,
  input  logic        [2:0]   i_noise,
  output logic signed [W-1:0] o_rpm,
  output logic                o_sat_hi,
  output logic                o_sat_lo,
  output logic                o_fault
);
  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] MAX_X = XW'(RPM_MAX);
  localparam logic signed [W-1:0]  MAX_W = W'(RPM_MAX);
  localparam logic [CW-1:0]        LIM   = CW'(SAT_LIMIT);

  logic signed [W-1:0]  r_x_q, r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_sat_hi, r_sat_lo, r_fault;

  logic signed [XW-1:0] w_x, w_acc, w_diff, w_step, w_noise, w_nxt;
  logic                 w_hi, w_lo;
  logic [CW-1:0]        w_cnt_nxt;

  // Widened to W+2 so neither the lag difference nor the sum can wrap
  assign w_x     = $signed({{2{r_x_q[W-1]}}, r_x_q});
  assign w_acc   = $signed({{2{r_acc[W-1]}}, r_acc});
  assign w_noise = $signed({{(XW-3){i_noise[2]}}, i_noise});
  assign w_diff  = (i_mode == LAG) ? (w_x - w_acc) : w_x;
  assign w_step  = w_diff >>> GAIN_SHIFT;
  assign w_nxt   = w_acc + w_step + w_noise;
  assign w_hi    = (w_nxt > MAX_X);
  assign w_lo    = w_nxt[XW-1];

  assign w_cnt_nxt = !w_hi ? '0 : (r_cnt == LIM) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_q    <= '0;
      r_acc    <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (i_tick) begin
        r_x_q    <= i_set;
        r_acc    <= w_hi ? MAX_W : w_lo ? '0 : w_nxt[W-1:0];
        r_sat_hi <= w_hi;
        r_sat_lo <= w_lo;
      end
      // Clear beats a same-edge increment
      if (i_fault_clr) begin
        r_cnt   <= '0;
        r_fault <= 1'b0;
      end else if (i_tick) begin
        r_cnt <= w_cnt_nxt;
        if (w_cnt_nxt == LIM) r_fault <= 1'b1;
      end
    end
  end

  assign o_rpm    = r_acc;
  assign o_sat_hi = r_sat_hi;
  assign o_sat_lo = r_sat_lo;
  assign o_fault  = r_fault;
endmodule

// File: rtl/motor_plant_model.sv
// N-channel motor plant model (mot_set -> rpm_sense) for controller HIL checks.
// Define MOTOR_NOISE_EN to add shared-LFSR noise (-4..+3) to each channel update.
module motor_plant_model
  import motor_plant_pkg::*;
#(
  parameter int NUM_MOT    = 4,
  parameter int W          = 16,
  parameter int GAIN_SHIFT = 3,
  parameter int RPM_MAX    = RPM_MAX_DEF,
  parameter int SAT_LIMIT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 mode,
  input  logic                 fault_clr,
  input  logic [NUM_MOT*W-1:0] mot_set,
  output logic [NUM_MOT*W-1:0] rpm_sense,
  output logic [NUM_MOT-1:0]   sat_hi,
  output logic [NUM_MOT-1:0]   sat_lo,
  output logic [NUM_MOT-1:0]   fault
);
  plant_mode_t                   w_mode;
  logic [NUM_MOT-1:0][2:0]       w_noise;
  logic [NUM_MOT-1:0][W-1:0]     w_rpm;

  assign w_mode = plant_mode_t'(mode);

`ifdef MOTOR_NOISE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset)     r_lfsr <= LFSR_SEED;
    else if (tick) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0);
  end

  // Slice index wraps mod 16 once NUM_MOT exceeds 5
  always_comb begin
    w_noise = '0;
    for (int k = 0; k < NUM_MOT; k++)
      for (int i = 0; i < 3; i++)
        w_noise[k][i] = r_lfsr[(3*k + i) % 16];
  end
`else
  assign w_noise = '0;
`endif

  for (genvar k = 0; k < NUM_MOT; k++) begin : g_ch
    motor_plant_ch #(
      .W         (W),
      .GAIN_SHIFT(GAIN_SHIFT),
      .RPM_MAX   (RPM_MAX),
      .SAT_LIMIT (SAT_LIMIT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_tick     (tick),
      .i_mode     (w_mode),
      .i_fault_clr(fault_clr),
      .i_set      (mot_set[k*W +: W]),
      .i_noise    (w_noise[k]),
      .o_rpm      (w_rpm[k]),
      .o_sat_hi   (sat_hi[k]),
      .o_sat_lo   (sat_lo[k]),
      .o_fault    (fault[k])
    );
  end

  assign rpm_sense = w_rpm;
endmodule

// File: tb/tb_motor_plant_model.sv
// Directed bench for motor_plant_model with an integer reference plant.
module tb_motor_plant_model;
  localparam int NM   = 4;
  localparam int W    = 16;
  localparam int GS   = 3;
  localparam int RMAX = 'h157C;
  localparam int SL   = 64;

  logic          clk = 1'b0;
  logic          reset, tick, mode, fault_clr;
  logic [NM*W-1:0] mot_set, rpm_sense;
  logic [NM-1:0] sat_hi, sat_lo, fault;
  logic signed [W-1:0] set_a [NM];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // reference plant state
  int m_xq [NM], m_acc [NM], m_cnt [NM];
  bit m_hi [NM], m_lo [NM], m_flt [NM];

  always #5 clk = ~clk;

  always_comb begin
    mot_set = '0;
    for (int k = 0; k < NM; k++) mot_set[k*W +: W] = set_a[k];
  end

  motor_plant_model #(
    .NUM_MOT(NM), .W(W), .GAIN_SHIFT(GS), .RPM_MAX(RMAX), .SAT_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode), .fault_clr(fault_clr),
    .mot_set(mot_set), .rpm_sense(rpm_sense),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .fault(fault)
  );

  function automatic int fdiv(int a);
    int d = 1 << GS;
    int q = a / d;
    if (a < 0 && q * d != a) q = q - 1;
    return q;
  endfunction

  task automatic model_step();
    int nx;
    for (int k = 0; k < NM; k++) begin
      if (reset) begin
        m_xq[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
        m_hi[k] = 0; m_lo[k] = 0; m_flt[k] = 0;
      end else begin
        if (tick) begin
          nx = m_acc[k] + fdiv(mode ? (m_xq[k] - m_acc[k]) : m_xq[k]);
          m_hi[k]  = (nx > RMAX);
          m_lo[k]  = (nx < 0);
          m_acc[k] = m_hi[k] ? RMAX : (m_lo[k] ? 0 : nx);
          m_xq[k]  = int'(set_a[k]);
          m_cnt[k] = m_hi[k] ? m_cnt[k] + 1 : 0;
        end
        if (fault_clr) begin
          m_cnt[k] = 0; m_flt[k] = 0;
        end else if (tick && m_cnt[k] >= SL) begin
          m_flt[k] = 1;
        end
      end
    end
  endtask

  function automatic logic [NM*W-1:0] exp_rpm();
    logic [NM*W-1:0] r = '0;
    for (int k = 0; k < NM; k++) r[k*W +: W] = m_acc[k][W-1:0];
    return r;
  endfunction

  function automatic logic [3*NM-1:0] exp_flags();
    logic [3*NM-1:0] r = '0;
    for (int k = 0; k < NM; k++) begin
      r[2*NM + k] = m_hi[k];
      r[NM + k]   = m_lo[k];
      r[k]        = m_flt[k];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rpm", rpm_sense, exp_rpm());
      chk("model_flags", {sat_hi, sat_lo, fault}, exp_flags());
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic setall(input logic signed [W-1:0] v);
    for (int k = 0; k < NM; k++) set_a[k] = v;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; mode = 1'b0; fault_clr = 1'b0;
    setall(16'sd80);
    @(negedge clk);
    cmp_en = 1'b1;

    // reset, then INTEG ramp at +10/tick after two-tick latency
    repeat (5) cyc();
    chk("rst_rpm", rpm_sense, 64'd0);
    chk("rst_flags", {sat_hi, sat_lo, fault}, 64'd0);
    reset = 1'b0;
    cyc(); chk("t1_rpm_a", rpm_sense[15:0], 64'd0);
    cyc(); chk("t1_rpm_b", rpm_sense[15:0], 64'd10);
    cyc(); chk("t1_rpm_c", rpm_sense[15:0], 64'd20);
    cyc(); chk("t1_rpm_d", rpm_sense[15:0], 64'd30);

    // negative commands: clamp to 0 with sat_lo; arithmetic shift of -1
    set_a[0] = -16'sd400; set_a[1] = -16'sd8; set_a[2] = 16'sd1000; set_a[3] = -16'sd1;
    cyc(); chk("t3_rpm_lat", rpm_sense[15:0], 64'd40);
    cyc(); chk("t3_rpm_clamp", rpm_sense[15:0], 64'd0);
    chk("t3_sat_lo", sat_lo[0], 64'd1);
    chk("t3_ch3_floor", rpm_sense[63:48], 64'd39);
    repeat (3) cyc();
    chk("t3_rpm_hold0", rpm_sense[15:0], 64'd0);

    // saturation at RPM_MAX and fault timing
    reset = 1'b1; setall(16'sh7FFF); cyc(); reset = 1'b0;
    cyc(); cyc();
    chk("t2_rpm_4095", rpm_sense[15:0], 64'd4095);
    cyc();
    chk("t2_rpm_max", rpm_sense[15:0], 64'h157C);
    chk("t2_sat_hi", sat_hi, 64'hF);
    repeat (SL - 2) cyc();
    chk("t2_no_fault_yet", fault, 64'h0);
    cyc();
    chk("t2_fault", fault, 64'hF);
    repeat (5) cyc();
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
    chk("t2_fault_clr", fault, 64'h0);
    repeat (SL - 1) cyc();
    chk("t2_refault_early", fault, 64'h0);
    cyc();
    chk("t2_refault", fault, 64'hF);

    // LAG step response, mode switch mid-run
    reset = 1'b1; mode = 1'b1; setall(16'sd800); cyc(); reset = 1'b0;
    cyc(); chk("t4_lag_0", rpm_sense[15:0], 64'd0);
    cyc(); chk("t4_lag_100", rpm_sense[15:0], 64'd100);
    cyc(); chk("t4_lag_187", rpm_sense[15:0], 64'd187);
    cyc(); chk("t4_lag_263", rpm_sense[15:0], 64'd263);
    mode = 1'b0; cyc();
    chk("t4_integ_363", rpm_sense[15:0], 64'd363);
    cyc(); mode = 1'b1; cyc();
    chk("t4_back_lag_505", rpm_sense[15:0], 64'd505);
    repeat (60) cyc();
    chk("t4_no_overshoot", 64'(rpm_sense[15:0] <= 16'd800), 64'd1);
    chk("t4_settled", 64'(rpm_sense[15:0] >= 16'd792), 64'd1);

    // reset mid-ramp at 500
    reset = 1'b1; mode = 1'b0; cyc(); reset = 1'b0;
    repeat (6) cyc();
    chk("t6_rpm_500", rpm_sense[15:0], 64'd500);
    reset = 1'b1; cyc();
    chk("t6_rst_rpm", rpm_sense, 64'd0);
    chk("t6_rst_flags", {sat_hi, sat_lo, fault}, 64'd0);

    // tick on 1 of 4 cycles
    reset = 1'b0; setall(16'sd80);
    for (int i = 0; i < 16; i++) begin
      tick = (i % 4 == 0);
      cyc();
      if (i == 6) chk("t5_rpm_mid", rpm_sense[15:0], 64'd10);
    end
    chk("t5_rpm_end", rpm_sense[15:0], 64'd30);
    tick = 1'b1;

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
